// File: rtl/nn_result_capture_if.sv
// nn_result_capture_if
//   Bundles the network-side capture inputs and the consumer-side result
//   queue handshake of nn_result_capture.
//   master : drives start/nn_out/nn_exc/out_ready/clr_ovf (host, bench)
//   slave  : the capture block; drives busy, head entry, count, overflow
interface nn_result_capture_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
);
  logic              start;
  logic [DATA_W-1:0] nn_out;
  logic [4:0]        nn_exc;
  logic              out_ready;
  logic              clr_ovf;
  logic              busy;
  logic              out_valid;
  logic [DATA_W-1:0] out_value;
  logic [4:0]        out_exc;
  logic              out_class;
  logic              out_nan;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  modport master (
    output start, nn_out, nn_exc, out_ready, clr_ovf,
    input  busy, out_valid, out_value, out_exc, out_class, out_nan,
           count, overflow
  );

  modport slave (
    input  start, nn_out, nn_exc, out_ready, clr_ovf,
    output busy, out_valid, out_value, out_exc, out_class, out_nan,
           count, overflow
  );
endinterface

// File: rtl/nn_result_capture.sv
// nn_result_capture
//   Arms on start, waits SETTLE_CYCLES for the combinational network to
//   settle, then samples nn_out/nn_exc in a single CAPTURE cycle, classifies
//   the value against THRESH (IEEE-754 ordering, NaN and negatives -> 0) and
//   pushes {class, nan, exc, value} into a small result FIFO.
//   Ports:
//     clk, rst_l : clock, async active-low reset
//     bus.slave  : start, nn_out, nn_exc, out_ready, clr_ovf in;
//                  busy, out_valid, out_value, out_exc, out_class, out_nan,
//                  count, overflow out
module nn_result_capture #(
  parameter int exp_width     = 8,
  parameter int mant_width    = 24,
  parameter int SETTLE_CYCLES = 64,
  parameter logic [exp_width+mant_width-1:0] THRESH = 32'h3F000000,
  parameter int FIFO_DEPTH    = 4
) (
  input logic                clk,
  input logic                rst_l,
  nn_result_capture_if.slave bus
);
  localparam int DW    = exp_width + mant_width;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0]  LOAD  = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

  typedef struct packed {
    logic          cls;
    logic          nan;
    logic [4:0]    exc;
    logic [DW-1:0] value;
  } entry_t;

  state_t          state, state_nx;
  logic [SC_W-1:0] cnt, cnt_nx;

  // ---------------- settle FSM ----------------
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = SETTLE;
          cnt_nx   = LOAD;
        end
      end
      SETTLE: begin
        // a fresh start restarts the settle window from the top
        if (bus.start)       cnt_nx   = LOAD;
        else if (cnt != '0)  cnt_nx   = cnt - 1'b1;
        else                 state_nx = CAPTURE;
      end
      CAPTURE: begin
        if (bus.start) begin
          state_nx = SETTLE;
          cnt_nx   = LOAD;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // ---------------- classification ----------------
  logic [exp_width-1:0]  fld_exp;
  logic [mant_width-2:0] fld_frac;
  logic                  fld_sign, is_nan, mag_gt;
  entry_t                cap;

  assign fld_sign = bus.nn_out[DW-1];
  assign fld_exp  = bus.nn_out[DW-2:mant_width-1];
  assign fld_frac = bus.nn_out[mant_width-2:0];
  assign is_nan   = (&fld_exp) && (|fld_frac);
  // for non-negative, non-NaN values the IEEE order matches the unsigned
  // order of the magnitude bits; +inf lands above any finite THRESH
  assign mag_gt   = bus.nn_out[DW-2:0] > THRESH[DW-2:0];

  assign cap.cls   = !is_nan && !fld_sign && mag_gt;
  assign cap.nan   = is_nan;
  assign cap.exc   = bus.nn_exc;
  assign cap.value = bus.nn_out;

  // ---------------- result FIFO ----------------
  entry_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic               ovf;
  logic               push_req, pop, full, push_ok, drop;

  assign push_req = (state == CAPTURE);
  assign pop      = (fifo_cnt != '0) && bus.out_ready;
  assign full     = (fifo_cnt == FULL);
  // a pop in the same cycle frees the slot the push needs
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && !push_ok;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= cap;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      // a drop in the same cycle as clr_ovf keeps the sticky bit set
      if (drop)             ovf <= 1'b1;
      else if (bus.clr_ovf) ovf <= 1'b0;
    end
  end

  entry_t head;
  assign head = mem[rd_ptr];

  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (fifo_cnt != '0);
  assign bus.out_value = head.value;
  assign bus.out_exc   = head.exc;
  assign bus.out_class = head.cls;
  assign bus.out_nan   = head.nan;
  assign bus.count     = fifo_cnt;
  assign bus.overflow  = ovf;
endmodule

// File: tb/tb_nn_result_capture.sv
module tb_nn_result_capture;
  localparam int S     = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  nn_result_capture_if #(.DATA_W(32), .CNT_W(3)) bus ();

  nn_result_capture #(
    .exp_width(8), .mant_width(24), .SETTLE_CYCLES(S),
    .THRESH(32'h3F000000), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_l(rst_l), .bus(bus)
  );

  typedef struct { logic [31:0] v; logic [4:0] e; } ent_t;
  ent_t q[$];
  bit   m_ovf;
  int   n_tests = 0;
  int   n_fail  = 0;

  // ---------- reference model (value-level IEEE semantics) ----------
  function automatic bit ref_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  function automatic real f2r(input logic [31:0] v);
    int  e;
    real m;
    e = int'(v[30:23]);
    if (e == 255)    m = 1.0e300;
    else if (e == 0) m = real'(v[22:0]) * (2.0 ** (-149));
    else             m = (1.0 + real'(v[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return v[31] ? -m : m;
  endfunction

  function automatic bit ref_class(input logic [31:0] v);
    return !ref_nan(v) && (f2r(v) > 0.5);
  endfunction

  // ---------- stimulus helpers (no checks) ----------
  // start pulse, garbage on nn_out/nn_exc outside the CAPTURE cycle
  task automatic capture(input logic [31:0] v, input logic [4:0] e,
                         input bit rdy, input bit clr);
    ent_t n;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int k = 1; k <= S + 1; k++) begin
      if (k == S + 1) begin
        bus.nn_out = v; bus.nn_exc = e; bus.out_ready = rdy; bus.clr_ovf = clr;
      end else begin
        bus.nn_out = $urandom; bus.nn_exc = 5'($urandom);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0; bus.clr_ovf = 1'b0;
    bus.nn_out = $urandom; bus.nn_exc = 5'($urandom);
    if (rdy && q.size() > 0) void'(q.pop_front());
    n.v = v; n.e = e;
    if (q.size() < DEPTH) q.push_back(n);
    else m_ovf = 1'b1;
    if (clr && q.size() <= DEPTH && !(q.size() == DEPTH && m_ovf && !rdy)) ;
  endtask

  task automatic pop_one();
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.out_ready = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  // ---------- tests ----------
  task automatic test_reset();
    rst_l = 1'b0;
    bus.start = 0; bus.nn_out = '0; bus.nn_exc = '0; bus.out_ready = 0; bus.clr_ovf = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_l = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({bus.busy, bus.out_valid, bus.count, bus.overflow} !== 6'b0 ||
        {bus.out_value, bus.out_exc, bus.out_class, bus.out_nan} !== 39'b0) begin
      n_fail++;
      $display("FAIL reset: busy=%b valid=%b count=%0d ovf=%b value=%h exc=%b cls=%b nan=%b, required all zero",
               bus.busy, bus.out_valid, bus.count, bus.overflow, bus.out_value, bus.out_exc,
               bus.out_class, bus.out_nan);
    end
    q.delete(); m_ovf = 0;
  endtask

  task automatic test_latency();
    bit busy_ok = 1, valid_ok = 1;
    ent_t n;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;     // edge E0
    if (bus.busy !== 1'b1) busy_ok = 0;
    for (int k = 1; k <= S + 1; k++) begin
      // cycle ending at edge E0+k is CAPTURE iff k == S+1
      if (k == S + 1) begin bus.nn_out = 32'h3F7FFF00; bus.nn_exc = 5'b10100; end
      else begin bus.nn_out = $urandom; bus.nn_exc = 5'($urandom); end
      @(posedge clk); #1;
      if (bus.busy !== (k <= S)) busy_ok = 0;
      if (bus.out_valid !== (k == S + 1)) valid_ok = 0;
    end
    bus.nn_out = $urandom;
    n.v = 32'h3F7FFF00; n.e = 5'b10100; q.push_back(n);
    n_tests++;
    if (!busy_ok) begin n_fail++; $display("FAIL latency_busy: busy window wrong, required high for edges E0..E0+%0d", S); end
    n_tests++;
    if (!valid_ok) begin n_fail++; $display("FAIL latency_valid: out_valid timing wrong, required first high after edge E0+%0d", S + 1); end
    n_tests++;
    if (bus.out_value !== 32'h3F7FFF00 || bus.out_class !== 1'b1 || bus.out_nan !== 1'b0 ||
        bus.out_exc !== 5'b10100) begin
      n_fail++;
      $display("FAIL latency_entry: value=%h cls=%b nan=%b exc=%b, required 3f7fff00 1 0 10100",
               bus.out_value, bus.out_class, bus.out_nan, bus.out_exc);
    end
    pop_one();
  endtask

  task automatic test_classify();
    logic [31:0] vals[$];
    logic [31:0] v;
    logic [4:0]  e;
    vals = '{32'h3C000000, 32'h3F000000, 32'h3F000001, 32'hBF800000,
             32'h80000000, 32'h7F800000, 32'h7FC00000, 32'hFF800000,
             32'h00000001, 32'hFFC00001};
    for (int i = 0; i < 8; i++) vals.push_back($urandom);
    for (int i = 0; i < 6; i++) vals.push_back(32'h3F000000 + 32'($urandom_range(0, 4)) - 32'd2);
    for (int i = 0; i < vals.size(); i++) begin
      v = vals[i];
      e = (i == 0) ? 5'b00001 : 5'($urandom);
      capture(v, e, 1'b0, 1'b0);
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_value !== q[0].v || bus.out_exc !== q[0].e ||
          bus.out_class !== ref_class(q[0].v) || bus.out_nan !== ref_nan(q[0].v)) begin
        n_fail++;
        $display("FAIL classify[%0d]: valid=%b value=%h exc=%b cls=%b nan=%b, required 1 %h %b %b %b",
                 i, bus.out_valid, bus.out_value, bus.out_exc, bus.out_class, bus.out_nan,
                 q[0].v, q[0].e, ref_class(q[0].v), ref_nan(q[0].v));
      end
      pop_one();
    end
    n_tests++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL classify_empty: count=%0d valid=%b, required 0 0", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_rearm();
    bit early = 0, busy_ok = 1;
    logic [31:0] v = 32'h40490FDB;
    ent_t n;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int k = 1; k <= 30 + S + 1; k++) begin
      bus.start  = (k == 30);
      bus.nn_out = (k == 30 + S + 1) ? v : $urandom;
      bus.nn_exc = 5'($urandom);
      @(posedge clk); #1;
      if (k < 30 + S + 1 && bus.out_valid !== 1'b0) early = 1;
      if (k <= 30 + S && bus.busy !== 1'b1) busy_ok = 0;
    end
    bus.start = 1'b0;
    n.v = v; n.e = 5'b0; q.push_back(n);
    n_tests++;
    if (early || !busy_ok) begin n_fail++; $display("FAIL rearm_window: early_valid=%b busy_ok=%b, required 0 1", early, busy_ok); end
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.count !== 3'd1 || bus.out_value !== v) begin
      n_fail++;
      $display("FAIL rearm_entry: valid=%b count=%0d value=%h, required 1 1 %h",
               bus.out_valid, bus.count, bus.out_value, v);
    end
    pop_one();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) capture($urandom, 5'($urandom), 1'b0, 1'b0);
    n_tests++;
    if (bus.count !== 3'(q.size()) || bus.overflow !== m_ovf) begin
      n_fail++; $display("FAIL ovf_set: count=%0d ovf=%b, required %0d %b", bus.count, bus.overflow, q.size(), m_ovf);
    end
    @(negedge clk) bus.clr_ovf = 1'b1;
    @(posedge clk); #1 bus.clr_ovf = 1'b0; m_ovf = 0;
    n_tests++;
    if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: ovf=%b, required 0", bus.overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_value !== q[0].v || bus.out_exc !== q[0].e) begin
        n_fail++;
        $display("FAIL ovf_drain[%0d]: valid=%b value=%h exc=%b, required 1 %h %b",
                 i, bus.out_valid, bus.out_value, bus.out_exc, q[0].v, q[0].e);
      end
      pop_one();
    end
    n_tests++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovf_empty: count=%0d valid=%b, required 0 0", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < DEPTH; i++) capture($urandom, 5'($urandom), 1'b0, 1'b0);
    capture(32'h3F400000, 5'b00011, 1'b1, 1'b0);    // pop + push same edge
    n_tests++;
    if (bus.count !== 3'd4 || bus.overflow !== 1'b0 || bus.out_value !== q[0].v) begin
      n_fail++;
      $display("FAIL full_pop: count=%0d ovf=%b head=%h, required 4 0 %h",
               bus.count, bus.overflow, bus.out_value, q[0].v);
    end
    capture(32'h12345678, 5'b0, 1'b0, 1'b1);        // drop while clearing: drop wins
    n_tests++;
    if (bus.overflow !== 1'b1 || m_ovf !== 1'b1) begin
      n_fail++; $display("FAIL drop_beats_clr: ovf=%b, required 1", bus.overflow);
    end
    @(negedge clk) bus.clr_ovf = 1'b1;
    @(posedge clk); #1 bus.clr_ovf = 1'b0; m_ovf = 0;
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++;
      if (bus.out_value !== q[0].v || bus.out_exc !== q[0].e || bus.out_class !== ref_class(q[0].v)) begin
        n_fail++;
        $display("FAIL full_drain[%0d]: value=%h exc=%b cls=%b, required %h %b %b",
                 i, bus.out_value, bus.out_exc, bus.out_class, q[0].v, q[0].e, ref_class(q[0].v));
      end
      pop_one();
    end
  endtask

  task automatic test_reset_mid_settle();
    bit ghost = 0;
    capture(32'h3F800000, 5'b0, 1'b0, 1'b0);
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_l = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b valid=%b count=%0d, required 0 0 0", bus.busy, bus.out_valid, bus.count);
    end
    q.delete(); m_ovf = 0;
    @(negedge clk) rst_l = 1'b1;
    for (int k = 0; k < S + 10; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) ghost = 1;
    end
    n_tests++;
    if (ghost) begin n_fail++; $display("FAIL reset_ghost: activity after aborted capture, required none"); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_classify();
    test_rearm();
    test_overflow();
    test_full_pop();
    test_reset_mid_settle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/nn_result_capture.md
# nn_result_capture

Downstream capture stage for the floating-point XOR network. The network output is combinational-settling and carries no valid strobe. This block is armed whenever new A/B operands are applied, and waits a fixed settle window. It then samples the network's output value and exception flags and classifies the value against a threshold using IEEE-754 ordering. Each result is queued in a small FIFO with a valid/ready interface for the consumer (result logger or host bus).

## Interface
- exp_width, 8, exponent field width
- mant_width, 24, significand width including hidden bit; data_width = exp_width + mant_width
- SETTLE_CYCLES, 64, cycles to wait after start before sampling (≥1)
- THRESH, 32'h3F000000 (0.5), classification threshold; must be positive, finite, non-NaN
- FIFO_DEPTH, 4, result queue depth; power of two, ≥2

- clk  input  1  clock
- rst_l  input  1  reset, asynchronous, active-low
- start  input  1  new operands applied to the network this cycle; arms capture
- nn_out  input  data_width  network output value
- nn_exc  input  5  network exception flags
- out_ready  input  1  consumer accepts the head entry
- clr_ovf  input  1  clears the overflow sticky bit
- busy  output  1  state ≠ IDLE
- out_valid  output  1  FIFO non-empty
- out_value  output  data_width  head entry value
- out_exc  output  5  head entry exception flags
- out_class  output  1  head entry: value > THRESH
- out_nan  output  1  head entry: value is NaN
- count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  output  1  sticky: a capture was dropped because the FIFO was full

## Operation
- Field split: sign = bit data_width-1; exponent = [data_width-2 : mant_width-1]; fraction = [mant_width-2 : 0].
- NaN: exponent all ones and fraction ≠ 0.
- Classification, computed on the sampled value:
  - NaN → class 0, nan 1.
  - Sign 1 (including -0, -inf) → class 0.
  - Otherwise class = unsigned compare of bits [data_width-2:0] > THRESH[data_width-2:0]; +inf → 1.
  - Equality → 0.
- FSM states: IDLE, SETTLE, CAPTURE.
  - IDLE: start → SETTLE, cnt ← SETTLE_CYCLES-1.
  - SETTLE: start → re-arm (cnt ← SETTLE_CYCLES-1, stay). Otherwise, cnt ≠ 0 → decrement; cnt = 0 → CAPTURE.
  - CAPTURE: sample {class, nan, nn_exc, nn_out} and push. Next state is SETTLE (re-armed) if start, else IDLE.
- Push is accepted if FIFO not full, or if a pop occurs in the same cycle. Otherwise the entry is dropped and overflow ← 1.
- Pop: out_valid && out_ready. The head advances at that edge.
- overflow clears on clr_ovf, unless a drop occurs in the same cycle; the drop wins.
- Read and write pointers wrap modulo FIFO_DEPTH. count tracks pushes minus pops.

## Timing
- Reset (async assert, sync-released by the clock): state IDLE, cnt 0, busy 0, out_valid 0, out_value/out_exc/out_class/out_nan 0, count 0, overflow 0. FIFO contents are discarded.
- Reset during SETTLE or CAPTURE aborts the pending capture; no entry is written.
- start sampled at edge E0 → SETTLE for SETTLE_CYCLES cycles → CAPTURE for 1 cycle. nn_out is sampled at edge E0+SETTLE_CYCLES+1.
- With the FIFO empty, out_valid rises after edge E0+SETTLE_CYCLES+1.
- Head outputs are registered FIFO data. They are stable while out_valid=1 && out_ready=0.
- Throughput: one capture per SETTLE_CYCLES+1 cycles. Back-to-back start held in CAPTURE gives no idle gap.
- nn_out and nn_exc are ignored outside the CAPTURE cycle.

## Test plan
- Latency: SETTLE_CYCLES=64, start pulse at cycle 10, nn_out=3F7FFF00 → out_valid first high after edge 75; busy high cycles 11–75; entry {value 3F7FFF00, class 1, nan 0}.
- Classification sweep, one capture each, out_ready=1:
  - 3C000000 → class 0
  - 3F000000 → class 0 (equal)
  - 3F000001 → class 1
  - BF800000 → class 0
  - 80000000 → class 0
  - 7F800000 → class 1
  - 7FC00000 → class 0, nan 1
  - nn_exc=5'b00001 is passed through in out_exc.
- Re-arm: start at cycle 0 and again at cycle 30 → only one capture, sampled at edge 30+SETTLE_CYCLES+1.
- Overflow: out_ready=0, five captures → count=4, overflow=1, FIFO holds the first four values in order. Then clr_ovf pulse → overflow=0. Then drain with out_ready=1 → four pops in order, count 0, out_valid 0.
- Full + simultaneous pop: FIFO full, out_ready=1 during the CAPTURE cycle → push accepted, count stays 4, overflow stays 0.
- Reset mid-SETTLE: assert rst_l=0 at cycle 20 after start → busy 0, out_valid 0, count 0 immediately. No entry ever appears.
